// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between the button and RX-echo
// byte sources; tracks serializer busy, enforces an inter-frame gap, flags start timeouts.
module uart_tx_scheduler #(
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_WAIT  = 4
) (
  input  logic       src_clk,
  input  logic       rst_n,
  input  logic       req_btn,
  input  logic [7:0] data_btn,
  output logic       ack_btn,
  input  logic       req_rx,
  input  logic [7:0] data_rx,
  output logic       ack_rx,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       sched_busy,
  output logic       err_timeout
);

  localparam int MAX_CNT = (GAP_CYCLES > BUSY_WAIT) ? GAP_CYCLES : BUSY_WAIT;
  localparam int CW      = $clog2(MAX_CNT + 2);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] WAIT_LIM = CW'(BUSY_WAIT);
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          prio_rx_q, prio_rx_d;
  logic          grant_btn, grant_rx, timeout;
  logic          tx_start_d, ack_btn_d, ack_rx_d, grant_id_d, err_timeout_d;
  logic [7:0]    tx_data_d;

  assign cnt_inc    = cnt_q + CW'(1);
  assign sched_busy = (state_q != IDLE);

  // NOTE: every variable gets a default first, so no path through the block infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_btn = 1'b0;
    grant_rx  = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A busy serializer blocks sampling entirely; requests wait at their level.
        if (!tx_busy) begin
          if (req_btn && (!req_rx || !prio_rx_q)) grant_btn = 1'b1;
          else if (req_rx)                        grant_rx  = 1'b1;
        end
        if (grant_btn || grant_rx) begin
          state_d = WAIT_BUSY;
          cnt_d   = '0;
        end
      end
      WAIT_BUSY: begin
        // Busy rising on the terminal count wins over the timeout.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_inc >= WAIT_LIM) begin
          timeout = 1'b1;
          cnt_d   = GAP_LOAD;
          if (NO_GAP) state_d = IDLE;
          else        state_d = GAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d = GAP_LOAD;
          if (NO_GAP) state_d = IDLE;
          else        state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q <= CW'(1)) state_d = IDLE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
    endcase
  end

  // Next values of the registered outputs; tx_data and grant_id hold between grants.
  always_comb begin
    tx_start_d    = grant_btn | grant_rx;
    ack_btn_d     = grant_btn;
    ack_rx_d      = grant_rx;
    err_timeout_d = timeout;
    tx_data_d     = tx_data;
    grant_id_d    = grant_id;
    prio_rx_d     = prio_rx_q;
    if (grant_btn) begin
      tx_data_d  = data_btn;
      grant_id_d = 1'b0;
      prio_rx_d  = 1'b1;
    end else if (grant_rx) begin
      tx_data_d  = data_rx;
      grant_id_d = 1'b1;
      prio_rx_d  = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge src_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prio_rx_q   <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      ack_btn     <= 1'b0;
      ack_rx      <= 1'b0;
      grant_id    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_rx_q   <= prio_rx_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      ack_btn     <= ack_btn_d;
      ack_rx      <= ack_rx_d;
      grant_id    <= grant_id_d;
      err_timeout <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: vector table, directed multi-cycle
// sequences, and randomized traffic against a transaction-timeline reference model.
module tb_uart_tx_scheduler;

  localparam int GAP = 16;
  localparam int BW  = 4;

  logic       src_clk, rst_n;
  logic       req_btn, req_rx, ack_btn, ack_rx;
  logic [7:0] data_btn, data_rx, tx_data;
  logic       tx_start, tx_busy, grant_id, sched_busy, err_timeout;

  logic force_busy, ser_en, cfg_never;
  int   cfg_d, cfg_len, ser_wait, ser_left;

  int n_checks, n_fail;

  typedef struct {
    logic        rst_n, rb, rr, fb;
    logic [7:0]  db, dr;
    logic [13:0] exp;
  } vec_t;
  vec_t vecs[$];

  logic [7:0] exp_seq [4] = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};

  uart_tx_scheduler #(.GAP_CYCLES(GAP), .BUSY_WAIT(BW)) dut (
    .src_clk    (src_clk),
    .rst_n      (rst_n),
    .req_btn    (req_btn),
    .data_btn   (data_btn),
    .ack_btn    (ack_btn),
    .req_rx     (req_rx),
    .data_rx    (data_rx),
    .ack_rx     (ack_rx),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .sched_busy (sched_busy),
    .err_timeout(err_timeout)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  // Serializer model: busy rises cfg_d cycles after it sees tx_start, lasts cfg_len cycles.
  always @(posedge src_clk) begin
    if (!ser_en) begin
      ser_wait <= 0;
      ser_left <= 0;
    end else if (tx_start) begin
      if (cfg_never)       begin ser_wait <= 0; ser_left <= 0; end
      else if (cfg_d == 0) ser_left <= cfg_len;
      else                 ser_wait <= cfg_d;
    end else if (ser_wait != 0) begin
      ser_wait <= ser_wait - 1;
      if (ser_wait == 1) ser_left <= cfg_len;
    end else if (ser_left != 0) begin
      ser_left <= ser_left - 1;
    end
  end

  assign tx_busy = ser_en ? (ser_left != 0) : force_busy;

  function automatic logic [13:0] pk(input logic s, ab, ar, gid, err, sb, input logic [7:0] d);
    return {s, ab, ar, gid, err, sb, d};
  endfunction

  function automatic logic [13:0] dut_out();
    return pk(tx_start, ack_btn, ack_rx, grant_id, err_timeout, sched_busy, tx_data);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, b, x, f, input logic [7:0] db, dr, input logic [13:0] e);
    vec_t v;
    v.rst_n = r; v.rb = b; v.rr = x; v.fb = f; v.db = db; v.dr = dr; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        got, prev_b, gb, win_rx, prio_rx, m_gid;
  logic [7:0]  m_data;
  int          starts, fall_at, drop_at, kind;
  int unsigned cyc, ready, err_at;
  logic        e_start, e_ab, e_ar;

  initial begin
    n_checks = 0; n_fail = 0;
    ser_en = 1'b0; force_busy = 1'b0; cfg_never = 1'b0; cfg_d = 0; cfg_len = 1;

    // Reset with both requests high, btn wins first, timeouts, rx grant, busy blocking.
    add_vec(0, 1, 1, 0, 8'h5A, 8'h33, pk(0, 0, 0, 0, 0, 0, 8'h00));
    add_vec(0, 1, 1, 0, 8'h5A, 8'h33, pk(0, 0, 0, 0, 0, 0, 8'h00));
    add_vec(1, 1, 1, 0, 8'h5A, 8'h33, pk(1, 1, 0, 0, 0, 1, 8'h5A));
    for (int k = 1; k <= BW + GAP; k++)
      add_vec(1, 0, 1, 0, 8'h5A, 8'h33, pk(0, 0, 0, 0, k == BW, k < BW + GAP, 8'h5A));
    add_vec(1, 0, 1, 0, 8'h5A, 8'h33, pk(1, 0, 1, 1, 0, 1, 8'h33));
    for (int k = 1; k <= BW + GAP; k++)
      add_vec(1, 0, 0, 0, 8'h5A, 8'h33, pk(0, 0, 0, 1, k == BW, k < BW + GAP, 8'h33));
    for (int k = 0; k < 3; k++)
      add_vec(1, 1, 0, 1, 8'hC3, 8'h33, pk(0, 0, 0, 1, 0, 0, 8'h33));
    add_vec(1, 1, 0, 0, 8'hC3, 8'h33, pk(1, 1, 0, 0, 0, 1, 8'hC3));
    add_vec(1, 0, 0, 0, 8'hC3, 8'h33, pk(0, 0, 0, 0, 0, 1, 8'hC3));
    add_vec(0, 0, 0, 0, 8'hC3, 8'h33, pk(0, 0, 0, 0, 0, 0, 8'h00));

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; req_btn = vecs[i].rb; req_rx = vecs[i].rr;
      force_busy = vecs[i].fb; data_btn = vecs[i].db; data_rx = vecs[i].dr;
      @(posedge src_clk); #1;
      check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // Single request, serializer busy for 100 cycles starting one cycle after tx_start.
    ser_en = 1'b1; cfg_never = 1'b0; cfg_d = 0; cfg_len = 100;
    rst_n = 1'b1; req_btn = 1'b1; data_btn = 8'h5A; req_rx = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin @(posedge src_clk); #1; got = ack_btn; end
    check("single_ack", got, 1);
    check("single_grant", dut_out(), pk(1, 1, 0, 0, 0, 1, 8'h5A));
    req_btn = 1'b0;
    starts = 0; fall_at = 0; drop_at = 0; prev_b = tx_busy;
    for (int i = 1; i <= 200; i++) begin
      @(posedge src_clk); #1;
      if (tx_start) starts++;
      if (prev_b && !tx_busy && fall_at == 0) fall_at = i;
      if (!sched_busy && drop_at == 0) drop_at = i;
      prev_b = tx_busy;
    end
    check("single_extra_start", starts, 0);
    check("single_gap_len", drop_at - fall_at, GAP + 1);
    check("single_hold", {grant_id, tx_data}, {1'b0, 8'h5A});

    // Contention: both held, expect strict alternation starting with btn.
    rst_n = 1'b0; @(posedge src_clk); #1; rst_n = 1'b1;
    cfg_d = 1; cfg_len = 20;
    req_btn = 1'b1; req_rx = 1'b1; data_btn = 8'hA1; data_rx = 8'hB2;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin @(posedge src_clk); #1; got = tx_start; end
      check($sformatf("cont%0d_start", k), got, 1);
      check($sformatf("cont%0d_data", k), tx_data, exp_seq[k]);
      check($sformatf("cont%0d_ack", k), {ack_btn, ack_rx}, (k % 2 == 0) ? 2'b10 : 2'b01);
    end

    // Reset during WAIT_DONE after a btn grant: pointer must return to btn priority.
    req_rx = 1'b0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin @(posedge src_clk); #1; got = ack_btn; end
    check("mid_grant_btn", got, 1);
    req_btn = 1'b0;
    repeat (6) @(posedge src_clk);
    #1;
    check("mid_in_frame", {sched_busy, tx_busy}, 2'b11);
    rst_n = 1'b0; req_btn = 1'b1; req_rx = 1'b1;
    @(posedge src_clk); #1;
    check("mid_reset_outputs", dut_out(), pk(0, 0, 0, 0, 0, 0, 8'h00));
    rst_n = 1'b1;
    got = 1'b0; gb = 1'b1; prev_b = tx_busy;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge src_clk); #1;
      if (tx_start) begin got = 1'b1; gb = prev_b; end
      prev_b = tx_busy;
    end
    check("mid_after_reset_grant", got, 1);
    check("mid_btn_priority", {ack_btn, ack_rx, tx_data}, {2'b10, 8'hA1});
    check("mid_grant_busy_low", gb, 0);

    // Randomized traffic against a timeline model of grant instants.
    req_btn = 1'b0; req_rx = 1'b0;
    repeat (60) @(posedge src_clk);
    #1;
    rst_n = 1'b0; @(posedge src_clk); #1; rst_n = 1'b1;
    cyc = 0; ready = 0; err_at = 0; prio_rx = 1'b0; m_data = 8'h00; m_gid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      req_btn  = ($urandom_range(0, 2) != 0);
      req_rx   = ($urandom_range(0, 2) != 0);
      data_btn = 8'($urandom);
      data_rx  = 8'($urandom);
      @(posedge src_clk); #1;
      cyc++;
      e_start = 1'b0; e_ab = 1'b0; e_ar = 1'b0;
      if (cyc >= ready && (req_btn || req_rx)) begin
        win_rx  = req_rx && (!req_btn || prio_rx);
        e_start = 1'b1; e_ab = !win_rx; e_ar = win_rx;
        m_data  = win_rx ? data_rx : data_btn;
        m_gid   = win_rx;
        prio_rx = !win_rx;
        kind = $urandom_range(0, 3);
        cfg_never = (kind == 3);
        cfg_d     = cfg_never ? 0 : kind;
        cfg_len   = $urandom_range(1, 8);
        // Busy is first seen cfg_d+2 edges after the grant; later than BW means timeout.
        if (cfg_never) begin
          err_at = cyc + BW;
          ready  = cyc + BW + GAP + 1;
        end else begin
          ready  = cyc + 3 + cfg_d + cfg_len + GAP;
        end
      end
      check($sformatf("rand%0d", i), dut_out(),
            pk(e_start, e_ab, e_ar, m_gid, cyc == err_at, cyc + 1 < ready, m_data));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
